stream_sequencer: RTL and testbench

//  Single-clock controller that sequences the I2S->FIFO->SPDIF sample path in the PLL clock domain.

---
 rtl/splitstreamer_pkg.sv | 16 +
 rtl/sync_edge.sv | 28 ++
 rtl/stream_sequencer.sv | 140 ++++++++++++++
 tb/tb_stream_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/splitstreamer_pkg.sv
// Shared constants for the I2S->FIFO->SPDIF sample-path sequencer.
package splitstreamer_pkg;

  // Debug-visible state encoding.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_PRIME    = 3'd2,
    ST_STREAM   = 3'd3,
    ST_UNDERRUN = 3'd4
  } state_e;

  localparam int DEF_PRIME_LEVEL = 8;     // half of a 16-pair FIFO
  localparam int DEF_LOCK_CYCLES = 1024;  // lock qualification window

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchroniser for an asynchronous level, plus rising-edge detect.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic r_s1, r_s2, r_s3;

  // Two metastability stages followed by one history stage for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/stream_sequencer.sv
// Sequencer for the I2S->FIFO->SPDIF path: lock qualification, frame
// alignment, FIFO priming, strobe generation and underrun recovery.
module stream_sequencer
  import splitstreamer_pkg::*;
#(
  parameter int LEVEL_W     = 5,
  parameter int PRIME_LEVEL = DEF_PRIME_LEVEL,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               fclk,
  input  logic               frame_req,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  output logic               write_en,
  output logic               read_en,
  output logic               validity,
  output logic               mute,
  output logic               dp_rst,
  output logic               red,
  output logic [CNT_W-1:0]   underrun_cnt,
  output logic [CNT_W-1:0]   overrun_cnt,
  output logic [2:0]         state
);

  localparam int                 LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] PRIME_LV  = LEVEL_W'(PRIME_LEVEL);

  logic w_lock, w_lock_rise_unused, w_fclk_level_unused, w_fclk_rise;

  sync_edge u_lock_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (pll_lock),
    .o_level(w_lock),
    .o_rise (w_lock_rise_unused)
  );

  sync_edge u_fclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (fclk),
    .o_level(w_fclk_level_unused),
    .o_rise (w_fclk_rise)
  );

  state_e            r_state, w_nxt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              w_wr, w_rd, w_ovr, w_und;
  logic              r_wr, r_rd, r_val, r_mute, r_dp_rst, r_red;
  logic [CNT_W-1:0]  r_und_cnt, r_ovr_cnt;

  // Count consecutive synced-lock cycles while waiting in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_lock_cnt <= '0;
    else if (!w_lock || r_state != ST_IDLE) r_lock_cnt <= '0;
    else if (r_lock_cnt != LOCK_LAST)       r_lock_cnt <= r_lock_cnt + 1'b1;
  end

  // Next state and strobe requests; lock loss overrides everything.
  always_comb begin
    w_nxt = r_state;
    w_wr  = 1'b0;
    w_rd  = 1'b0;
    w_ovr = 1'b0;
    w_und = 1'b0;
    case (r_state)
      ST_IDLE:     if (r_lock_cnt == LOCK_LAST) w_nxt = ST_SYNC;
      // The first rise only marks a frame boundary; its frame was partial.
      ST_SYNC:     if (w_fclk_rise) w_nxt = ST_PRIME;
      ST_PRIME: begin
        w_wr = w_fclk_rise & ~fifo_full;
        if (fifo_level >= PRIME_LV) w_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        w_wr  = w_fclk_rise & ~fifo_full;
        w_ovr = w_fclk_rise &  fifo_full;
        if (frame_req) begin
          if (fifo_empty) begin
            w_und = 1'b1;
            w_nxt = ST_UNDERRUN;
          end else begin
            w_rd = 1'b1;
          end
        end
      end
      // FIFO contents are kept; refill to the prime level before reading.
      ST_UNDERRUN: w_nxt = ST_PRIME;
      default:     w_nxt = ST_IDLE;
    endcase
    if (!w_lock) begin
      w_nxt = ST_IDLE;
      w_wr  = 1'b0;
      w_rd  = 1'b0;
      w_ovr = 1'b0;
      w_und = 1'b0;
    end
  end

  // State, registered state-decoded outputs, strobes and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_dp_rst  <= 1'b1;
      r_mute    <= 1'b1;
      r_red     <= 1'b1;
      r_val     <= 1'b0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_und_cnt <= '0;
      r_ovr_cnt <= '0;
    end else begin
      r_state  <= w_nxt;
      r_dp_rst <= (w_nxt == ST_IDLE);
      r_mute   <= (w_nxt != ST_STREAM);
      r_red    <= (w_nxt != ST_STREAM);
      r_val    <= (w_nxt == ST_STREAM);
      r_wr     <= w_wr;
      r_rd     <= w_rd;
      if (w_und && r_und_cnt != {CNT_W{1'b1}}) r_und_cnt <= r_und_cnt + 1'b1;
      if (w_ovr && r_ovr_cnt != {CNT_W{1'b1}}) r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign write_en     = r_wr;
  assign read_en      = r_rd;
  assign validity     = r_val;
  assign mute         = r_mute;
  assign dp_rst       = r_dp_rst;
  assign red          = r_red;
  assign underrun_cnt = r_und_cnt;
  assign overrun_cnt  = r_ovr_cnt;
  assign state        = r_state;

endmodule

// File: tb/tb_stream_sequencer.sv
// Scoreboard bench for stream_sequencer: randomized frame timing, a FIFO
// occupancy model, and expected strobe cycles queued at stimulus time.
module tb_stream_sequencer;

  localparam int LW = 5;
  localparam int PL = 8;
  localparam int LC = 16;
  localparam int CW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0, rst_n = 1'b0, pll_lock = 1'b0, fclk = 1'b0, frame_req = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          fifo_full, fifo_empty;
  logic          write_en, read_en, validity, mute, dp_rst, red;
  logic [CW-1:0] underrun_cnt, overrun_cnt;
  logic [2:0]    state;

  int lvl = 0;
  bit force_full = 1'b0, force_empty = 1'b0;
  int cyc = 0;
  int checks = 0, errors = 0;
  int exp_und = 0, exp_ovr = 0;
  int wq[$];
  int rq[$];

  stream_sequencer #(.LEVEL_W(LW), .PRIME_LEVEL(PL), .LOCK_CYCLES(LC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .fclk(fclk), .frame_req(frame_req),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .write_en(write_en), .read_en(read_en), .validity(validity), .mute(mute),
    .dp_rst(dp_rst), .red(red), .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_level = LW'(lvl);
  assign fifo_full  = force_full  || (lvl >= DEPTH);
  assign fifo_empty = force_empty || (lvl == 0);

  // FIFO occupancy: strobes seen in a cycle take effect at the following edge.
  always @(negedge clk) begin
    bit pw, pr, pd;
    pw = write_en; pr = read_en; pd = dp_rst;
    @(posedge clk); #1;
    if (pd) lvl = 0;
    else begin
      if (pw && lvl < DEPTH) lvl = lvl + 1;
      if (pr && lvl > 0)     lvl = lvl - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected cycle.
  always @(negedge clk) if (rst_n) begin
    if (write_en) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected write_en: got 1 expected 0 (cycle %0d)", cyc);
      end else chk("write_en cycle", cyc, wq.pop_front());
    end
    if (read_en) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected read_en: got 1 expected 0 (cycle %0d)", cyc);
      end else chk("read_en cycle", cyc, rq.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One fclk period of p cycles, optional frame_req at offset off.
  // A pin rise shows up as write_en 3 cycles later; frame_req as read_en 1 later.
  task automatic frame(input int p, input int off, input bit exp_wr, input bit exp_rd, input bit do_req);
    for (int i = 0; i < p; i++) begin
      step();
      fclk      = (i < p / 2);
      frame_req = do_req && (i == off);
      if (i == 0 && exp_wr) wq.push_back(cyc + 3);
      if (do_req && i == off && exp_rd) rq.push_back(cyc + 1);
    end
  endtask

  task automatic chk_streaming(input string nm);
    chk({nm, " state"}, state, 3);
    chk({nm, " validity"}, validity, 1);
    chk({nm, " mute"}, mute, 0);
    chk({nm, " red"}, red, 0);
    chk({nm, " level"}, lvl, PL);
  endtask

  // Lock rising now: SYNC is reached LOCK_CYCLES + 2 cycles later.
  task automatic lock_qual();
    pll_lock = 1'b1;
    step(LC + 1);
    chk("lock still IDLE", state, 0);
    step();
    chk("lock SYNC", state, 1);
    chk("SYNC dp_rst", dp_rst, 0);
    chk("SYNC mute", mute, 1);
  endtask

  // Discarded alignment rise, then exactly PL accepted writes.
  task automatic prime_run();
    frame($urandom_range(8, 20), 0, 1'b0, 1'b0, 1'b0);
    chk("PRIME entered", state, 2);
    chk("PRIME validity", validity, 0);
    for (int k = 0; k < PL; k++)
      frame($urandom_range(8, 20), $urandom_range(0, 2), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    step(2);
    chk_streaming("after prime");
  endtask

  task automatic stream_run(input int n);
    for (int k = 0; k < n; k++) begin
      int p, off;
      p   = $urandom_range(8, 24);
      off = ($urandom_range(0, 2) == 0) ? 2 : $urandom_range(0, p - 2);
      frame(p, off, 1'b1, 1'b1, 1'b1);
    end
    step(2);
    chk_streaming("stream");
  endtask

  initial begin
    int c;
    step(3);
    chk("rst state", state, 0);
    chk("rst dp_rst", dp_rst, 1);
    chk("rst mute", mute, 1);
    chk("rst red", red, 1);
    chk("rst write_en", write_en, 0);
    chk("rst read_en", read_en, 0);
    chk("rst validity", validity, 0);
    chk("rst underrun_cnt", underrun_cnt, 0);
    chk("rst overrun_cnt", overrun_cnt, 0);
    rst_n = 1'b1;
    step(2);

    // Lock that drops before qualification must not leave IDLE.
    pll_lock = 1'b1;
    step(10);
    pll_lock = 1'b0;
    step(8);
    chk("short lock state", state, 0);
    chk("short lock dp_rst", dp_rst, 1);

    lock_qual();
    prime_run();
    stream_run(20);

    // Underrun: request against an empty FIFO.
    force_empty = 1'b1;
    step();
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    exp_und = (exp_und < 255) ? exp_und + 1 : 255;
    chk("UNDERRUN state", state, 4);
    chk("UNDERRUN mute", mute, 1);
    chk("UNDERRUN validity", validity, 0);
    step();
    chk("post-underrun PRIME", state, 2);
    chk("post-underrun mute", mute, 1);
    chk("underrun_cnt", underrun_cnt, exp_und);
    force_empty = 1'b0;
    step();
    chk("FIFO kept -> STREAM", state, 3);
    stream_run(3);

    // Overrun: full FIFO, writes dropped and counted with saturation.
    force_full = 1'b1;
    for (int k = 0; k < 300; k++) begin
      frame($urandom_range(4, 6), 0, 1'b0, 1'b0, 1'b0);
      exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
      if (k == 99) chk("overrun_cnt 100", overrun_cnt, exp_ovr);
    end
    chk("overrun_cnt sat", overrun_cnt, exp_ovr);
    chk("overrun stays STREAM", state, 3);
    force_full = 1'b0;
    stream_run(3);

    // Lock loss mid-stream: IDLE within 3 cycles, counters kept.
    pll_lock = 1'b0;
    step(2);
    chk("lock loss not yet", state, 3);
    step();
    chk("lock loss IDLE", state, 0);
    chk("lock loss dp_rst", dp_rst, 1);
    chk("lock loss red", red, 1);
    chk("lock loss underrun kept", underrun_cnt, exp_und);
    chk("lock loss overrun kept", overrun_cnt, exp_ovr);
    step(5);
    lock_qual();
    prime_run();
    stream_run(4);

    // Reset with a read strobe in flight.
    step();
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    chk("in-flight read_en", read_en, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst read_en", read_en, 0);
    chk("async rst state", state, 0);
    chk("async rst dp_rst", dp_rst, 1);
    chk("async rst mute", mute, 1);
    chk("async rst red", red, 1);
    chk("async rst validity", validity, 0);
    chk("async rst underrun_cnt", underrun_cnt, 0);
    chk("async rst overrun_cnt", overrun_cnt, 0);
    step(3);
    c = wq.size();
    chk("pending writes", c, 0);
    c = rq.size();
    chk("pending reads", c, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
